traffic_spawner: RTL and testbench

TRAFFIC_SPAWNER -- requirements
Module: traffic_spawner

---
 rtl/traffic_spawner_pkg.sv | 13 +
 rtl/traffic_spawner_lfsr16.sv | 13 +
 rtl/traffic_spawner.sv | 117 +++++++++++
 tb/tb_traffic_spawner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/traffic_spawner_pkg.sv
// traffic_spawner_pkg: shared game constants, FSM state enum and lane geometry helper
package traffic_spawner_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE, S_FROZEN} state_t;
  localparam int GAME_SCREEN_H = 480;
  localparam int GAME_LANE_X0 = 200;
  localparam int GAME_LANE_PITCH = 80;
  localparam int GAME_TRAFFIC_W = 40;
  localparam int GAME_TRAFFIC_H = 60;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic logic [9:0] lane_x(input logic [1:0] r, input int x0, input int pitch);
    return 10'(x0 + ((r == 2'd3) ? 0 : int'(r)) * pitch);
  endfunction
endpackage

// File: rtl/traffic_spawner_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11); ports clk, reset_n, en, state
module lfsr16
  import traffic_spawner_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  output logic [15:0] state
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= LFSR_SEED;
    else if (en) state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
endmodule

// File: rtl/traffic_spawner.sv
// traffic_spawner: spawns/moves one obstacle; in clk reset_n frame_tick run restart collision, out traffic box/valid, passed, speed, crashed
module traffic_spawner
  import traffic_spawner_pkg::*;
#(
  parameter int SCREEN_H = GAME_SCREEN_H,
  parameter int LANE_X0 = GAME_LANE_X0,
  parameter int LANE_PITCH = GAME_LANE_PITCH,
  parameter int TRAFFIC_W = GAME_TRAFFIC_W,
  parameter int TRAFFIC_H = GAME_TRAFFIC_H,
  parameter int SPEED_INIT = 2,
  parameter int SPEED_MAX = 8,
  parameter int PASSES_PER_LEVEL = 4,
  parameter int SPAWN_GAP = 30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       run,
  input  logic       restart,
  input  logic       collision,
  output logic [9:0] traffic_x,
  output logic [9:0] traffic_y,
  output logic [9:0] traffic_width,
  output logic [9:0] traffic_height,
  output logic       traffic_valid,
  output logic       passed,
  output logic [3:0] speed,
  output logic       crashed
);
  state_t state, state_nxt;
  logic [9:0] x_nxt, y_nxt;
  logic valid_nxt, passed_nxt;
  logic [3:0] speed_nxt;
  logic [7:0] pass_cnt, pass_nxt;
  logic [15:0] gap, gap_nxt;
  logic [15:0] lfsr;
  logic lfsr_unused;
  logic [10:0] y_sum;
  logic last_pass;
  lfsr16 u_lfsr (.clk(clk), .reset_n(reset_n), .en(1'b1), .state(lfsr));
  assign lfsr_unused = ^lfsr[15:2];
  assign traffic_width = 10'(TRAFFIC_W);
  assign traffic_height = 10'(TRAFFIC_H);
  // 11-bit sum so the bottom-edge test cannot wrap
  assign y_sum = {1'b0, traffic_y} + {7'd0, speed};
  assign last_pass = (pass_cnt + 8'd1) == 8'(PASSES_PER_LEVEL);
  always_comb begin
    state_nxt = state;
    x_nxt = traffic_x;
    y_nxt = traffic_y;
    valid_nxt = traffic_valid;
    passed_nxt = 1'b0;
    speed_nxt = speed;
    pass_nxt = pass_cnt;
    gap_nxt = gap;
    if (restart) begin
      state_nxt = S_IDLE;
      x_nxt = '0;
      y_nxt = '0;
      valid_nxt = 1'b0;
      speed_nxt = 4'(SPEED_INIT);
      pass_nxt = '0;
      gap_nxt = '0;
    end else begin
      case (state)
        S_IDLE: if (run) begin
          state_nxt = S_WAIT;
          gap_nxt = 16'(SPAWN_GAP);
        end
        S_WAIT: if (run && frame_tick) begin
          gap_nxt = gap - 16'd1;
          if (gap <= 16'd1) begin
            state_nxt = S_DRIVE;
            gap_nxt = '0;
            x_nxt = lane_x(lfsr[1:0], LANE_X0, LANE_PITCH);
            y_nxt = '0;
            valid_nxt = 1'b1;
          end
        end
        S_DRIVE: if (collision) state_nxt = S_FROZEN;
          else if (run && frame_tick) begin
            if (y_sum >= 11'(SCREEN_H)) begin
              state_nxt = S_WAIT;
              valid_nxt = 1'b0;
              passed_nxt = 1'b1;
              gap_nxt = 16'(SPAWN_GAP);
              pass_nxt = last_pass ? 8'd0 : pass_cnt + 8'd1;
              speed_nxt = (last_pass && speed != 4'(SPEED_MAX)) ? speed + 4'd1 : speed;
            end else y_nxt = y_sum[9:0];
          end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      traffic_x <= '0;
      traffic_y <= '0;
      traffic_valid <= 1'b0;
      passed <= 1'b0;
      crashed <= 1'b0;
      speed <= 4'(SPEED_INIT);
      pass_cnt <= '0;
      gap <= '0;
    end else begin
      state <= state_nxt;
      traffic_x <= x_nxt;
      traffic_y <= y_nxt;
      traffic_valid <= valid_nxt;
      passed <= passed_nxt;
      crashed <= state_nxt == S_FROZEN;
      speed <= speed_nxt;
      pass_cnt <= pass_nxt;
      gap <= gap_nxt;
    end
endmodule

// File: tb/tb_traffic_spawner.sv
// tb_traffic_spawner: directed stimulus with a frame-level behavioural model and per-cycle compare
module tb_traffic_spawner;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_tick = 1'b0, run = 1'b0, restart = 1'b0, collision = 1'b0;
  logic [9:0] traffic_x, traffic_y, traffic_width, traffic_height;
  logic traffic_valid, passed, crashed;
  logic [3:0] speed;
  int checks = 0, failures = 0;
  traffic_spawner dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .run(run), .restart(restart),
    .collision(collision), .traffic_x(traffic_x), .traffic_y(traffic_y),
    .traffic_width(traffic_width), .traffic_height(traffic_height),
    .traffic_valid(traffic_valid), .passed(passed), .speed(speed), .crashed(crashed)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: phase 0 idle, 1 waiting for spawn, 2 moving, 3 crashed.
  // Speed is derived from total passes since restart rather than tracked.
  int m_phase, m_x, m_y, m_gap, m_total;
  bit m_valid, m_passed;
  logic [15:0] m_lf;
  function automatic int m_speed(input int total);
    int s;
    s = 2 + total / 4;
    return (s > 8) ? 8 : s;
  endfunction
  always @(posedge clk or negedge reset_n) begin : model
    int ph, x, y, g, t, lane;
    bit v, p;
    if (!reset_n) begin
      m_phase <= 0; m_x <= 0; m_y <= 0; m_gap <= 0; m_total <= 0;
      m_valid <= 0; m_passed <= 0; m_lf <= 16'hACE1;
    end else begin
      ph = m_phase; x = m_x; y = m_y; g = m_gap; t = m_total; v = m_valid; p = 0;
      lane = (m_lf[1:0] == 2'd3) ? 0 : int'(m_lf[1:0]);
      if (restart) begin
        ph = 0; x = 0; y = 0; g = 0; t = 0; v = 0;
      end else if (ph == 0) begin
        if (run) begin ph = 1; g = 30; end
      end else if (ph == 1) begin
        if (run && frame_tick) begin
          g = g - 1;
          if (g == 0) begin ph = 2; y = 0; x = 200 + 80 * lane; v = 1; end
        end
      end else if (ph == 2) begin
        if (collision) ph = 3;
        else if (run && frame_tick) begin
          if (y + m_speed(t) >= 480) begin ph = 1; v = 0; p = 1; t = t + 1; g = 30; end
          else y = y + m_speed(t);
        end
      end
      m_phase <= ph; m_x <= x; m_y <= y; m_gap <= g; m_total <= t; m_valid <= v; m_passed <= p;
      m_lf <= {m_lf[14:0], m_lf[15] ^ m_lf[13] ^ m_lf[12] ^ m_lf[10]};
    end
  end
  always @(negedge clk) begin
    check("cmp_x", int'(traffic_x), m_x);
    check("cmp_y", int'(traffic_y), m_y);
    check("cmp_valid", int'(traffic_valid), int'(m_valid));
    check("cmp_passed", int'(passed), int'(m_passed));
    check("cmp_speed", int'(speed), m_speed(m_total));
    check("cmp_crashed", int'(crashed), int'(m_phase == 3));
    check("cmp_width", int'(traffic_width), 40);
    check("cmp_height", int'(traffic_height), 60);
  end
  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask
  task automatic until_passes(input int target, input string name);
    int budget;
    budget = 0;
    frame_tick = 1'b1;
    while (m_total < target && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    frame_tick = 1'b0;
    check(name, int'(budget < 6000), 1);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_valid", int'(traffic_valid), 0);
    check("rst_speed", int'(speed), 2);
    check("rst_y", int'(traffic_y), 0);
    reset_n = 1'b1;
    run = 1'b1;
    @(negedge clk);
    ticks(30);
    check("spawn_valid", int'(traffic_valid), 1);
    check("spawn_y", int'(traffic_y), 0);
    check("spawn_lane", int'(traffic_x == 200 || traffic_x == 280 || traffic_x == 360), 1);
    ticks(239);
    check("pre_pass_y", int'(traffic_y), 478);
    check("pre_pass_passed", int'(passed), 0);
    ticks(1);
    check("pass_pulse", int'(passed), 1);
    check("pass_valid", int'(traffic_valid), 0);
    @(negedge clk);
    check("pass_pulse_end", int'(passed), 0);
    until_passes(4, "budget_4");
    check("level_speed3", int'(speed), 3);
    until_passes(24, "budget_24");
    check("sat_speed8", int'(speed), 8);
    until_passes(28, "budget_28");
    check("sat_speed_hold", int'(speed), 8);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_speed", int'(speed), 2);
    check("restart_valid", int'(traffic_valid), 0);
    @(negedge clk);
    ticks(30);
    ticks(50);
    check("y_100", int'(traffic_y), 100);
    collision = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    frame_tick = 1'b0;
    check("frozen_crashed", int'(crashed), 1);
    check("frozen_y", int'(traffic_y), 100);
    check("frozen_valid", int'(traffic_valid), 1);
    ticks(10);
    check("frozen_y_hold", int'(traffic_y), 100);
    restart = 1'b1;
    collision = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    collision = 1'b0;
    check("rc_valid", int'(traffic_valid), 0);
    check("rc_speed", int'(speed), 2);
    check("rc_crashed", int'(crashed), 0);
    @(negedge clk);
    collision = 1'b1;
    repeat (3) @(negedge clk);
    collision = 1'b0;
    check("wait_coll_ignored", int'(crashed), 0);
    ticks(30);
    ticks(10);
    check("drive_y20", int'(traffic_y), 20);
    run = 1'b0;
    ticks(20);
    check("pause_y", int'(traffic_y), 20);
    run = 1'b1;
    ticks(5);
    check("resume_y", int'(traffic_y), 30);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_valid", int'(traffic_valid), 0);
    check("async_y", int'(traffic_y), 0);
    check("async_x", int'(traffic_x), 0);
    check("async_speed", int'(speed), 2);
    check("async_passed", int'(passed), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ticks(30);
    check("respawn_valid", int'(traffic_valid), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
